gray_step_decoder: RTL and testbench
====================================

// Module: gray_step_decoder
// PURPOSE
//   Receiving end of the 4-bit Gray-code counter link: samples an asynchronous Gray bus
//   (counter output, switches or rotary encoder), synchronises and filters it, and converts
//   it to binary. Classifies each accepted change as an up step, a down step or an error,
//   and keeps a signed running position. Sits between board I/O and the display/control logic.
// PARAMETERS
//   WIDTH          4   Gray bus width
//   SYNC_STAGES    2   synchroniser flops per bit (>=2)
//   STABLE_CYCLES  4   consecutive identical samples required before a value is accepted (>=1)
//   POS_W          8   width of the signed position counter
// PORTS
//   clk          in   1        system clock
//   rst          in   1        asynchronous, active-low reset
//   gray_in      in   WIDTH    asynchronous Gray-code input
//   err_clr      in   1        synchronous clear of err_sticky
//   binary_out   out  WIDTH    binary value of the last accepted code
//   step_valid   out  1        one-cycle pulse: accepted code is adjacent to the previous one
//   step_up      out  1        direction, qualified by step_valid (1 = +1, 0 = -1)
//   step_err     out  1        one-cycle pulse: accepted code is non-adjacent
//   err_sticky   out  1        set by step_err, held until err_clr
//   position     out  POS_W    two's-complement running step count
// BEHAVIOUR
//   Reset (rst = 0, asynchronous):
//     - all outputs and synchroniser flops go to 0; FSM enters S_IDLE; primed = 0.
//   Synchroniser:
//     - SYNC_STAGES flops per bit; the last stage is the sample value s.
//   Filter FSM:
//     - S_IDLE: when s != cand, load cand = s, clear stab_cnt, go to S_SETTLE.
//     - S_SETTLE: stab_cnt increments while s == cand.
//     - If s changes, reload cand, restart stab_cnt and stay in S_SETTLE.
//     - When stab_cnt reaches STABLE_CYCLES-1 with s == cand, commit and go to S_IDLE.
//   Commit:
//     - nb = gray2bin(cand); d = (nb - binary_out) mod 2^WIDTH.
//     - primed == 0: binary_out <= nb, primed <= 1, no pulse, position unchanged.
//     - d == 0 (bounce returned to old value): no pulse, nothing updated.
//     - d == 1: step_valid = 1, step_up = 1, position + 1.
//     - d == 2^WIDTH-1: step_valid = 1, step_up = 0, position - 1.
//     - otherwise: step_err = 1, err_sticky set; binary_out still updated, position held.
//     - binary_out updates on every commit with d != 0.
//   Latency:
//     - From the first clk edge at which new gray_in is captured by sync stage 1,
//       step pulses and binary_out change exactly SYNC_STAGES + STABLE_CYCLES cycles later.
//   Wrap-around:
//     - 15 -> 0 is up; 0 -> 15 is down.
//     - position wraps modulo 2^POS_W with no saturation and no flag.
//   Simultaneous events:
//     - err_clr in the same cycle as step_err: set wins, err_sticky = 1.
//     - step_valid and step_err are mutually exclusive.
//   Pulse rules:
//     - pulses last exactly one cycle.
//     - step_up is 0 whenever step_valid is 0.
//   gray_in stable from reset: the first commit occurs after the filter latency and only primes.
// STRUCTURE
//   gray_pkg (shared with the counter):
//     - functions bin2gray() and gray2bin(), parameterised by WIDTH;
//     - typedef enum logic {S_IDLE, S_SETTLE} filt_state_e;
//     - localparam GRAY_W = 4.
//   Sub-module:
//     - sync_ff #(WIDTH, STAGES): multi-bit flop synchroniser, async active-low reset.
//   Top level:
//     - filter FSM and commit/classify logic in one always_ff;
//     - d computation as combinational logic.
// TESTING
//   1 Prime: release reset with gray_in=4'b0000, wait 10 cycles
//     -> binary_out=0, no pulses, position=0.
//   2 Up count: drive 0000,0001,0011,0010, each held 8 cycles
//     -> three step_valid pulses with step_up=1, position=3, binary_out=3;
//        each pulse at +6 cycles with the defaults.
//   3 Wrap: from binary 15 (gray 1000) drive 0000 -> step_up=1, binary_out=0;
//     then drive 1000 -> step_up=0, position back to its previous value.
//   4 Bounce: from gray 0001 toggle to 0011 for 2 cycles, back to 0001, then hold
//     -> no pulse, binary_out=1, position unchanged.
//   5 Error: from gray 0000 jump to 0110 (binary 4)
//     -> step_err pulse, err_sticky=1, binary_out=4, position held;
//     err_clr in the same cycle as a second error -> err_sticky stays 1.
//   6 Reset mid-settle: assert rst 2 cycles after a gray_in change
//     -> all outputs 0 immediately (asynchronous); after release the next stable value only primes.

Source files
------------

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg : Gray/binary conversion helpers and filter state type shared by
//            the Gray-code counter and its receiving decoder.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic {S_IDLE, S_SETTLE} filt_state_e;

  // Operate on zero-extended 32-bit vectors so any WIDTH <= 32 converts
  // correctly; callers truncate the result back to WIDTH.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_step_decoder_sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff : multi-bit flop chain synchroniser with async active-low reset.
//           Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module sync_ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_step_decoder.sv
// ---------------------------------------------------------------------------
// gray_step_decoder : synchronise, debounce and decode an async Gray bus into
//                     up/down/error steps and a signed running position. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH         = GRAY_W,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int POS_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] binary_out,
  output logic             step_valid,
  output logic             step_up,
  output logic             step_err,
  output logic             err_sticky,
  output logic [POS_W-1:0] position
);

  localparam int              CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] delta;

  filt_state_e      state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  sync_ff #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (gray_in),
    .q_o   (s)
  );

  assign nb    = WIDTH'(gray2bin(32'(cand_q)));
  assign delta = nb - bin_q;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    bin_d    = bin_q;
    pos_d    = pos_q;
    valid_d  = 1'b0;
    up_d     = 1'b0;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    case (state_q)
      // An unprimed decoder must settle once even if the bus never moves.
      S_IDLE: begin
        if ((s != cand_q) || !primed_q) begin
          cand_d  = s;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (s != cand_q) begin
          cand_d = s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          if (!primed_q) begin
            bin_d    = nb;
            primed_d = 1'b1;
          end else if (delta != '0) begin
            bin_d = nb;
            if (delta == WIDTH'(1)) begin
              valid_d = 1'b1;
              up_d    = 1'b1;
              pos_d   = pos_q + POS_W'(1);
            end else if (delta == '1) begin
              valid_d = 1'b1;
              pos_d   = pos_q - POS_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    if (err_d) begin
      sticky_d = 1'b1;
    end else if (err_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      bin_q    <= '0;
      pos_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
      bin_q    <= bin_d;
      pos_q    <= pos_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign binary_out = bin_q;
  assign step_valid = valid_q;
  assign step_up    = up_q;
  assign step_err   = err_q;
  assign err_sticky = sticky_q;
  assign position   = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_step_decoder.sv
// ---------------------------------------------------------------------------
// tb_gray_step_decoder : directed self-checking bench for gray_step_decoder.
//                        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] gray_in = 4'b0000;
  logic       err_clr = 1'b0;
  logic [3:0] binary_out;
  logic       step_valid;
  logic       step_up;
  logic       step_err;
  logic       err_sticky;
  logic [7:0] position;

  int checks = 0;
  int errors = 0;

  gray_step_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .binary_out (binary_out),
    .step_valid (step_valid),
    .step_up    (step_up),
    .step_err   (step_err),
    .err_sticky (err_sticky),
    .position   (position)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new code and hold it 8 cycles; the result must appear exactly
  // 6 edges after the first capturing edge and last a single cycle.
  task automatic apply_step(input string tag, input logic [3:0] g,
                            input logic ev, input logic eu, input logic ee,
                            input logic [3:0] eb, input logic [7:0] ep);
    gray_in = g;
    repeat (6) tick();
    check({tag, "_early"}, 32'({step_valid, step_err}), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(step_valid), 32'(ev));
    check({tag, "_up"},    32'(step_up),    32'(eu));
    check({tag, "_err"},   32'(step_err),   32'(ee));
    check({tag, "_bin"},   32'(binary_out), 32'(eb));
    check({tag, "_pos"},   32'(position),   32'(ep));
    tick();
    check({tag, "_once"}, 32'({step_valid, step_err}), 32'd0);
  endtask

  logic [3:0] seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                           4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110,
                           4'b1010, 4'b1011, 4'b1001, 4'b1000};

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_bin",    32'(binary_out), 32'd0);
    check("rst_pos",    32'(position),   32'd0);
    check("rst_flags",  32'({step_valid, step_up, step_err, err_sticky}), 32'd0);

    // Prime with a bus that never moves
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("prime_nopulse%0d", i), 32'({step_valid, step_err}), 32'd0);
    end
    check("prime_bin", 32'(binary_out), 32'd0);
    check("prime_pos", 32'(position),   32'd0);

    // Count up 1..15
    for (int i = 1; i < 16; i++) begin
      apply_step($sformatf("up%0d", i), seq[i], 1'b1, 1'b1, 1'b0, 4'(i), 8'(i));
    end

    // Wrap-around both directions
    apply_step("wrap_up",   4'b0000, 1'b1, 1'b1, 1'b0, 4'd0,  8'd16);
    apply_step("wrap_dn",   4'b1000, 1'b1, 1'b0, 1'b0, 4'd15, 8'd15);
    apply_step("wrap_up2",  4'b0000, 1'b1, 1'b1, 1'b0, 4'd0,  8'd16);
    apply_step("to_one",    4'b0001, 1'b1, 1'b1, 1'b0, 4'd1,  8'd17);

    // Bounce returns to the old code before it is stable
    gray_in = 4'b0011;
    repeat (2) tick();
    gray_in = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("bounce_nopulse%0d", i), 32'({step_valid, step_err}), 32'd0);
    end
    check("bounce_bin", 32'(binary_out), 32'd1);
    check("bounce_pos", 32'(position),   32'd17);

    // Error on a non-adjacent jump
    apply_step("back0", 4'b0000, 1'b1, 1'b0, 1'b0, 4'd0, 8'd16);
    apply_step("err1",  4'b0110, 1'b0, 1'b0, 1'b1, 4'd4, 8'd16);
    check("err1_sticky", 32'(err_sticky), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_sticky", 32'(err_sticky), 32'd0);

    // Second error coinciding with err_clr: set wins
    gray_in = 4'b1100;
    repeat (6) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err2_err",    32'(step_err),   32'd1);
    check("err2_valid",  32'(step_valid), 32'd0);
    check("err2_bin",    32'(binary_out), 32'd8);
    check("err2_pos",    32'(position),   32'd16);
    check("err2_sticky", 32'(err_sticky), 32'd1);
    tick();
    check("err2_hold",   32'(err_sticky), 32'd1);

    // Reset in the middle of a settle window
    gray_in = 4'b1101;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("async_bin",    32'(binary_out), 32'd0);
    check("async_pos",    32'(position),   32'd0);
    check("async_sticky", 32'(err_sticky), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      check($sformatf("reprime_nopulse%0d", i), 32'({step_valid, step_err}), 32'd0);
    end
    check("reprime_bin", 32'(binary_out), 32'd9);
    check("reprime_pos", 32'(position),   32'd0);
    apply_step("after_rst", 4'b1111, 1'b1, 1'b1, 1'b0, 4'd10, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
